// File: rtl/bj_key_command_decoder_if.sv
// Command channel between the key decoder (master) and the blackjack game FSM (slave).
// A token transfers on every rising clock edge where cmd_valid and cmd_ready are both 1.
// While cmd_valid is high and cmd_ready is low, cmd is held stable.
// cmd_ready may be asserted or removed at any time; it has no effect while cmd_valid is 0.
interface bj_key_command_decoder_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/bj_key_command_decoder.sv
// Turns raw push-buttons into debounced deal/stand/hit tokens on a valid/ready channel.
// Each accepted level rise gives exactly one token; lost presses are flagged in a sticky overrun bit.
module bj_key_command_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
    input  logic                            CLOCK_50,
    input  logic                            resetn,
    input  logic [2:0]                      key_raw,
    input  logic                            clr_overrun,
    bj_key_command_decoder_if.master        cmd_if,
    output logic [2:0]                      key_level,
    output logic                            overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CODE_DEAL  = 2'b01;
    localparam logic [1:0] CODE_HIT   = 2'b10;
    localparam logic [1:0] CODE_STAND = 2'b11;

    logic [2:0]       p_raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       level_d;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    logic             valid_q;
    logic [1:0]       cmd_q;
    logic             cand_valid;
    logic [1:0]       cand_code;
    logic             multi;
    logic             accept;
    logic             drop;

    assign p_raw = key_raw ^ {3{KEY_ACTIVE_LOW}};

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1   <= '0;
            sync2   <= '0;
            level_d <= '0;
        end else begin
            sync1   <= p_raw;
            sync2   <= sync1;
            level_d <= key_level;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 3; k++) begin
                cnt[k] <= '0;
            end
            key_level <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == key_level[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    cnt[k]       <= '0;
                    key_level[k] <= ~key_level[k];
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press = key_level & ~level_d;

    // Deal beats stand beats hit; every losing event of the same cycle is a drop.
    always_comb begin
        cand_valid = |press;
        cand_code  = 2'b00;
        if (press[0]) begin
            cand_code = CODE_DEAL;
        end else if (press[1]) begin
            cand_code = CODE_STAND;
        end else if (press[2]) begin
            cand_code = CODE_HIT;
        end
        multi  = (press[0] & (press[1] | press[2])) | (press[1] & press[2]);
        accept = valid_q & cmd_if.cmd_ready;
        drop   = multi | (cand_valid & valid_q & ~accept);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            cmd_q   <= 2'b00;
            overrun <= 1'b0;
        end else begin
            if (cand_valid && (!valid_q || accept)) begin
                valid_q <= 1'b1;
                cmd_q   <= cand_code;
            end else if (accept) begin
                valid_q <= 1'b0;
                cmd_q   <= 2'b00;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign cmd_if.cmd_valid = valid_q;
    assign cmd_if.cmd       = cmd_q;

endmodule

// File: tb/tb_bj_key_command_decoder.sv
// Bench for bj_key_command_decoder: directed scenarios plus randomized key activity
// checked against a window-based behavioural model of debounce, priority and handshake.
module tb_bj_key_command_decoder;

    localparam int D = 16;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [2:0] key_raw  = 3'b000;
    logic       clr_overrun = 1'b0;
    logic [2:0] key_level;
    logic       overrun;

    bj_key_command_decoder_if cif ();

    bj_key_command_decoder #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20),
        .KEY_ACTIVE_LOW  (1'b0)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .key_raw     (key_raw),
        .clr_overrun (clr_overrun),
        .cmd_if      (cif),
        .key_level   (key_level),
        .overrun     (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    // Reference model state
    logic [2:0] m_p1, m_p2, m_level, m_rise;
    logic [2:0] s_hist[$];
    logic       m_valid, m_ovr;
    logic [1:0] m_cmd;

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_level = '0; m_rise = '0;
        s_hist.delete();
        m_valid = 1'b0; m_cmd = 2'b00; m_ovr = 1'b0;
    endtask

    // A key's level flips once the last D synchronized samples all disagree with it.
    task automatic model_edge();
        logic [2:0] s, old_level;
        logic [1:0] code;
        logic       acc, drp, all_diff;
        int         n;
        s    = m_p2;
        n    = $countones(m_rise);
        code = m_rise[0] ? 2'b01 : m_rise[1] ? 2'b11 : m_rise[2] ? 2'b10 : 2'b00;
        acc  = m_valid && cif.cmd_ready;
        if (acc) exp_q.push_back(m_cmd);
        drp = (n > 1) || (n > 0 && m_valid && !acc);
        if (n > 0 && (!m_valid || acc)) begin
            m_valid = 1'b1; m_cmd = code;
        end else if (acc) begin
            m_valid = 1'b0; m_cmd = 2'b00;
        end
        if (drp) m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
        s_hist.push_back(s);
        if (s_hist.size() > D) s_hist.delete(0);
        old_level = m_level;
        if (s_hist.size() == D) begin
            for (int k = 0; k < 3; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (s_hist[j][k] == old_level[k]) all_diff = 1'b0;
                end
                if (all_diff) m_level[k] = ~m_level[k];
            end
        end
        m_rise = m_level & ~old_level;
        m_p2 = m_p1;
        m_p1 = key_raw;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        if (cif.cmd_valid && cif.cmd_ready) got_q.push_back(cif.cmd);
        @(posedge CLOCK_50);
        if (!resetn) model_reset();
        else model_edge();
        @(negedge CLOCK_50);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic settle();
        key_raw = 3'b000;
        cif.cmd_ready = 1'b1;
        ticks(30);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cif.cmd_ready = 1'b0;
        model_reset();
        ticks(3);
        checks++; if (cif.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", cif.cmd_valid); end
        checks++; if (cif.cmd !== 2'b00) begin errors++; $display("FAIL rst_cmd got %b exp 00", cif.cmd); end
        checks++; if (key_level !== 3'b000) begin errors++; $display("FAIL rst_level got %b exp 000", key_level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        resetn = 1'b1;
        ticks(2);
    endtask

    task automatic test_single_deal();
        int first, hi;
        first = 0; hi = 0;
        cif.cmd_ready = 1'b1;
        key_raw = 3'b001;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (cif.cmd_valid === 1'b1) begin
                hi++;
                if (first == 0) first = i;
            end
        end
        checks++; if (first != 19) begin errors++; $display("FAIL deal_latency got %0d exp 19", first); end
        checks++; if (hi != 1) begin errors++; $display("FAIL deal_width got %0d exp 1", hi); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 2'b01) begin errors++; $display("FAIL deal_tokens got n=%0d exp one 01", got_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL deal_overrun got %b exp 0", overrun); end
        checks++; if (key_level !== m_level) begin errors++; $display("FAIL deal_level got %b exp %b", key_level, m_level); end
        settle();
    endtask

    task automatic test_bounce_hit();
        int first;
        logic [2:0] pat;
        first = 0;
        cif.cmd_ready = 1'b1;
        for (int i = 1; i <= 53; i++) begin
            pat = (i <= 5 || i >= 9) ? 3'b100 : 3'b000;
            key_raw = pat;
            tick();
            if (cif.cmd_valid === 1'b1 && first == 0) first = i;
        end
        checks++; if (first != 27) begin errors++; $display("FAIL bounce_latency got %0d exp 27", first); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 2'b10) begin errors++; $display("FAIL bounce_tokens got n=%0d exp one 10", got_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bounce_overrun got %b exp 0", overrun); end
        settle();
    endtask

    task automatic test_overrun_hold();
        cif.cmd_ready = 1'b0;
        key_raw = 3'b100;
        ticks(30);
        key_raw = 3'b110;
        ticks(30);
        checks++; if (cif.cmd_valid !== 1'b1 || cif.cmd !== 2'b10) begin errors++; $display("FAIL hold_cmd got %b/%b exp 1/10", cif.cmd_valid, cif.cmd); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL hold_overrun got %b exp 1", overrun); end
        cif.cmd_ready = 1'b1;
        tick();
        cif.cmd_ready = 1'b0;
        checks++; if (cif.cmd_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got %b exp 0", cif.cmd_valid); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 2'b10) begin errors++; $display("FAIL hold_tokens got n=%0d exp one 10", got_q.size()); end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hold_clear got %b exp 0", overrun); end
        settle();
    endtask

    task automatic test_same_cycle_priority();
        cif.cmd_ready = 1'b1;
        key_raw = 3'b011;
        ticks(40);
        checks++; if (got_q.size() != 1 || got_q[0] !== 2'b01) begin errors++; $display("FAIL prio_tokens got n=%0d exp one 01", got_q.size()); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL prio_overrun got %b exp 1", overrun); end
        settle();
    endtask

    task automatic test_back_to_back();
        cif.cmd_ready = 1'b0;
        key_raw = 3'b100;
        ticks(25);
        key_raw = 3'b110;
        ticks(18);
        checks++; if (cif.cmd_valid !== 1'b1 || cif.cmd !== 2'b10) begin errors++; $display("FAIL b2b_pre got %b/%b exp 1/10", cif.cmd_valid, cif.cmd); end
        cif.cmd_ready = 1'b1;
        tick();
        checks++; if (cif.cmd_valid !== 1'b1 || cif.cmd !== 2'b11) begin errors++; $display("FAIL b2b_next got %b/%b exp 1/11", cif.cmd_valid, cif.cmd); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        tick();
        checks++; if (got_q.size() != 2 || got_q[0] !== 2'b10 || got_q[1] !== 2'b11) begin errors++; $display("FAIL b2b_tokens got n=%0d exp 10,11", got_q.size()); end
        settle();
    endtask

    task automatic test_reset_mid_operation();
        cif.cmd_ready = 1'b0;
        key_raw = 3'b001;
        ticks(25);
        key_raw = 3'b011;
        ticks(25);
        key_raw = 3'b111;
        ticks(8);
        resetn = 1'b0;
        key_raw = 3'b100;
        model_reset();
        #1;
        checks++; if (cif.cmd_valid !== 1'b0 || cif.cmd !== 2'b00) begin errors++; $display("FAIL mid_rst_cmd got %b/%b exp 0/00", cif.cmd_valid, cif.cmd); end
        checks++; if (overrun !== 1'b0 || key_level !== 3'b000) begin errors++; $display("FAIL mid_rst_state got %b/%b exp 0/000", overrun, key_level); end
        @(negedge CLOCK_50);
        ticks(3);
        resetn = 1'b1;
        cif.cmd_ready = 1'b1;
        ticks(30);
        checks++; if (got_q.size() != 1 || got_q[0] !== 2'b10) begin errors++; $display("FAIL mid_rst_tokens got n=%0d exp one 10", got_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun got %b exp 0", overrun); end
        settle();
    endtask

    task automatic test_random();
        int hold, n;
        for (int seg = 0; seg < 70; seg++) begin
            key_raw = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                cif.cmd_ready = ($urandom_range(0, 3) != 0);
                clr_overrun = ($urandom_range(0, 15) == 0);
                tick();
                checks++; if (cif.cmd_valid !== m_valid || cif.cmd !== m_cmd) begin errors++; $display("FAIL rnd_cmd seg %0d got %b/%b exp %b/%b", seg, cif.cmd_valid, cif.cmd, m_valid, m_cmd); end
                checks++; if (key_level !== m_level) begin errors++; $display("FAIL rnd_level seg %0d got %b exp %b", seg, key_level, m_level); end
                checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun seg %0d got %b exp %b", seg, overrun, m_ovr); end
            end
        end
        clr_overrun = 1'b0;
        key_raw = 3'b000;
        cif.cmd_ready = 1'b1;
        ticks(30);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_token %0d got %b exp %b", i, got_q[i], exp_q[i]); end
        end
        settle();
    endtask

    initial begin
        cif.cmd_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_deal();
        test_bounce_hit();
        test_overrun_hold();
        test_same_cycle_priority();
        test_back_to_back();
        test_reset_mid_operation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
